// File: rtl/instr_aligner.sv
// Halfword realignment buffer between a word-aligned fetch port and the compressed
// decoder: packs 16- and 32-bit RISC-V instructions from a 3-entry halfword FIFO.
module instr_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  output logic [31:0] pc_o,
  output logic        instr_err_o
);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid never depends on ready in the same cycle.

  logic [15:0] hw_q [3];
  logic [2:0]  err_q;
  logic [1:0]  count_q;
  logic [31:0] pc_q;
  logic        skip_q;

  logic [15:0] hw_s [3];
  logic [15:0] hw_n [3];
  logic [2:0]  err_s;
  logic [2:0]  err_n;
  logic [1:0]  count_n;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic [1:0]  base;
  logic [1:0]  base_p1;
  logic        head_comp;
  logic        avail;
  logic        instr_hs;
  logic        fetch_hs;

  assign head_comp = (hw_q[0][1:0] != 2'b11);
  assign pc_o      = pc_q;

  // A lone uncompressed halfword with a bus error is released on its own so
  // the error can reach the decoder without waiting for a second halfword.
  assign avail = ((count_q != 2'd0) && head_comp) || (count_q >= 2'd2) ||
                 ((count_q == 2'd1) && err_q[0]);

  always_comb begin
    instr_valid_o   = 1'b0;
    instr_o         = 32'h0;
    instr_err_o     = 1'b0;
    is_compressed_o = 1'b0;
    if (rst_ni) begin
      is_compressed_o = head_comp;
      instr_valid_o   = avail && !flush_i;
      if (head_comp || (count_q < 2'd2)) begin
        instr_o     = {16'h0000, hw_q[0]};
        instr_err_o = err_q[0];
      end else begin
        instr_o     = {hw_q[1], hw_q[0]};
        instr_err_o = err_q[0] | err_q[1];
      end
    end
  end

  assign fetch_ready_o = rst_ni && (count_q <= 2'd1) && !flush_i;
  assign fetch_hs      = fetch_valid_i && fetch_ready_o;
  assign instr_hs      = instr_valid_o && instr_ready_i;

  always_comb begin
    pop_n = 2'd0;
    if (instr_hs) begin
      if (head_comp || (count_q < 2'd2)) pop_n = 2'd1;
      else                               pop_n = 2'd2;
    end
    push_n = 2'd0;
    if (fetch_hs) push_n = skip_q ? 2'd1 : 2'd2;
  end

  always_comb begin
    hw_s  = hw_q;
    err_s = err_q;
    case (pop_n)
      2'd1: begin
        hw_s[0] = hw_q[1];
        hw_s[1] = hw_q[2];
        err_s   = {err_q[2], err_q[2:1]};
      end
      2'd2: begin
        hw_s[0] = hw_q[2];
        err_s   = {err_q[2:1], err_q[2]};
      end
      default: ;
    endcase
    base    = count_q - pop_n;
    base_p1 = base + 2'd1;
    hw_n    = hw_s;
    err_n   = err_s;
    // Pushes only occur with count <= 1, so base_p1 never exceeds 2.
    if (fetch_hs) begin
      if (skip_q) begin
        hw_n[base]  = fetch_rdata_i[31:16];
        err_n[base] = fetch_err_i;
      end else begin
        hw_n[base]     = fetch_rdata_i[15:0];
        err_n[base]    = fetch_err_i;
        hw_n[base_p1]  = fetch_rdata_i[31:16];
        err_n[base_p1] = fetch_err_i;
      end
    end
    count_n = base + push_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_q    <= '{default: 16'h0000};
      err_q   <= 3'b000;
      count_q <= 2'd0;
      pc_q    <= BOOT_ADDR & 32'hFFFF_FFFE;
      skip_q  <= BOOT_ADDR[1];
    end else if (flush_i) begin
      count_q <= 2'd0;
      pc_q    <= flush_pc_i & 32'hFFFF_FFFE;
      skip_q  <= flush_pc_i[1];
    end else begin
      hw_q    <= hw_n;
      err_q   <= err_n;
      count_q <= count_n;
      if (instr_hs) pc_q <= pc_q + (head_comp ? 32'd2 : 32'd4);
      if (fetch_hs && skip_q) skip_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner: per-cycle vector table plus stall,
// refill and mid-operation reset sequences.
module tb_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic        is_compressed_o;
  logic [31:0] pc_o;
  logic        instr_err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        ir;
    logic        e_fr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_c;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  instr_aligner dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_rdata_i(fetch_rdata_i), .fetch_err_i(fetch_err_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .is_compressed_o(is_compressed_o), .pc_o(pc_o),
    .instr_err_o(instr_err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic fv,
                              input logic [31:0] fd, input logic fe, input logic ir,
                              input logic e_fr, input logic e_v, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_c, input logic e_err);
    vec_t r;
    r.fl = fl; r.fpc = fpc; r.fv = fv; r.fd = fd; r.fe = fe; r.ir = ir;
    r.e_fr = e_fr; r.e_v = e_v; r.e_instr = e_instr; r.e_pc = e_pc;
    r.e_c = e_c; r.e_err = e_err;
    return r;
  endfunction

  // driver: apply inputs on the falling edge
  task automatic drive(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] fd, input logic fe, input logic ir);
    @(negedge clk_i);
    flush_i = fl; flush_pc_i = fpc; fetch_valid_i = fv;
    fetch_rdata_i = fd; fetch_err_i = fe; instr_ready_i = ir;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"}, {31'h0, instr_valid_o}, 32'h0);
    chk({tag, ".fready"}, {31'h0, fetch_ready_o}, 32'h0);
    chk({tag, ".instr"}, instr_o, 32'h0);
    chk({tag, ".comp"}, {31'h0, is_compressed_o}, 32'h0);
    chk({tag, ".err"}, {31'h0, instr_err_o}, 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'h0; fetch_err_i = 1'b0; instr_ready_i = 1'b0;

    //           fl fpc           fv fd            fe ir   fr v  instr         pc            c  err
    vecs.push_back(mk(0, 32'h0,   1, 32'h00130513, 0, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00130513, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h4,        1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h6,        1, 0));
    vecs.push_back(mk(1, 32'h0,   1, 32'hDEADBEEF, 0, 1,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h45050505, 0, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000505, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00004505, 32'h2,        1, 0));
    vecs.push_back(mk(1, 32'h0,   0, 32'h0,        0, 0,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h05130001, 0, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h45010013, 0, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00130513, 32'h2,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00004501, 32'h6,        1, 0));
    vecs.push_back(mk(1, 32'h102, 0, 32'h0,        0, 0,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h0505FFFF, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000505, 32'h102,      1, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h104,      1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h106,      1, 0));
    vecs.push_back(mk(1, 32'h2,   0, 32'h0,        0, 0,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h05130000, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010013, 1, 1,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00130513, 32'h2,        0, 1));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h6,        1, 1));
    vecs.push_back(mk(1, 32'h2,   0, 32'h0,        0, 0,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00130000, 1, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000013, 32'h2,        0, 1));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h6,        1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h8,        1, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFE, 0, 32'h0,   0, 0,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010000, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 1,   1, 1, 32'h00000001, 32'hFFFFFFFE, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h2,        1, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h41,  0, 32'h0,        0, 1,   0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h00010001, 0, 0,   1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   0, 1, 32'h00000001, 32'h40,       1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1,   1, 1, 32'h00000001, 32'h42,       1, 0));

    // reset state
    repeat (2) @(negedge clk_i);
    #1;
    check_reset_outputs("rst");
    chk("rst.pc", pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_rel.fready", {31'h0, fetch_ready_o}, 32'h1);
    chk("rst_rel.valid", {31'h0, instr_valid_o}, 32'h0);

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].fpc, vecs[i].fv, vecs[i].fd, vecs[i].fe, vecs[i].ir);
      chk($sformatf("vec%0d.fready", i), {31'h0, fetch_ready_o}, {31'h0, vecs[i].e_fr});
      chk($sformatf("vec%0d.valid", i), {31'h0, instr_valid_o}, {31'h0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d.instr", i), instr_o, vecs[i].e_instr);
        chk($sformatf("vec%0d.pc", i), pc_o, vecs[i].e_pc);
        chk($sformatf("vec%0d.comp", i), {31'h0, is_compressed_o}, {31'h0, vecs[i].e_c});
        chk($sformatf("vec%0d.err", i), {31'h0, instr_err_o}, {31'h0, vecs[i].e_err});
      end
    end

    // stall with a full FIFO, then drain with refill
    drive(1, 32'h2, 0, 32'h0, 0, 0);
    drive(0, 32'h0, 1, 32'h00010000, 0, 0);
    drive(0, 32'h0, 1, 32'h45054501, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 32'h0, 1, 32'h0, 0, 0);
      chk($sformatf("stall%0d.fready", c), {31'h0, fetch_ready_o}, 32'h0);
      chk($sformatf("stall%0d.valid", c), {31'h0, instr_valid_o}, 32'h1);
      chk($sformatf("stall%0d.instr", c), instr_o, 32'h00000001);
      chk($sformatf("stall%0d.pc", c), pc_o, 32'h2);
      chk($sformatf("stall%0d.comp", c), {31'h0, is_compressed_o}, 32'h1);
    end
    exp_q = '{32'h00000001, 32'h00004501, 32'h00004505, 32'h00000001, 32'h00000001};
    exp_pc_q = '{32'h2, 32'h4, 32'h6, 32'h8, 32'hA};
    begin
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
        drive(0, 32'h0, 1, 32'h00010001, 0, 1);
        if (instr_valid_o && instr_ready_i) begin
          chk($sformatf("drain%0d.instr", k), instr_o, exp_q.pop_front());
          chk($sformatf("drain%0d.pc", k), pc_o, exp_pc_q.pop_front());
          if (k == 2) chk("drain2.refill_ready", {31'h0, fetch_ready_o}, 32'h1);
          k++;
        end
        cyc++;
      end
      chk("drain.remaining", exp_q.size(), 32'h0);
    end

    // reset asserted mid-operation
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("mid_rel.fready", {31'h0, fetch_ready_o}, 32'h1);
    chk("mid_rel.valid", {31'h0, instr_valid_o}, 32'h0);
    drive(0, 32'h0, 1, 32'h00130513, 0, 0);
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    chk("mid_after.valid", {31'h0, instr_valid_o}, 32'h1);
    chk("mid_after.instr", instr_o, 32'h00130513);
    chk("mid_after.pc", pc_o, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    chk("mid_after.drained", {31'h0, instr_valid_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, PC of the first instruction after reset (bit 0 zero).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush_i  input  1  discard all buffered halfwords and restart at flush_pc_i.
REQ-005 SHALL have port flush_pc_i  input  32  restart PC; bit 0 ignored, bit 1 may be set.
REQ-006 SHALL have port fetch_valid_i  input  1  fetch word present.
REQ-007 SHALL have port fetch_ready_o  output  1  aligner accepts the fetch word this cycle.
REQ-008 SHALL have port fetch_rdata_i  input  32  word-aligned fetch data, little-endian halfwords.
REQ-009 SHALL have port fetch_err_i  input  1  bus error for the whole fetch word.
REQ-010 SHALL have port instr_valid_o  output  1  complete instruction presented to the compressed decoder.
REQ-011 SHALL have port instr_ready_i  input  1  decode stage consumes the instruction.
REQ-012 SHALL have port instr_o  output  32  raw instruction; 16-bit forms in [15:0] with [31:16] zero.
REQ-013 SHALL have port is_compressed_o  output  1  instr_o[1:0] != 2'b11.
REQ-014 SHALL have port pc_o  output  32  PC of instr_o.
REQ-015 SHALL have port instr_err_o  output  1  at least one halfword of instr_o carried fetch_err_i.

Function
REQ-016 SHALL hold a FIFO of up to 3 halfwords, each with its own err bit; count in 0..3.
REQ-017 SHALL drive fetch_ready_o = (count <= 1) && !flush_i, from registered count only, with no dependence on the same-cycle instruction handshake.
REQ-018 SHALL, on a fetch handshake, append halfwords [15:0] then [31:16], both tagged with fetch_err_i, unless skip_q is set.
REQ-019 SHALL, when skip_q is set, append only [31:16] and clear skip_q on that handshake.
REQ-020 SHALL assert instr_valid_o when count >= 1 and head[1:0] != 2'b11, or when count >= 2.
REQ-021 SHALL also assert instr_valid_o when count == 1, head[1:0] == 2'b11 and the head err bit is set; instr_err_o=1, upper half zero, size 4.
REQ-022 SHALL form instr_o combinationally from FIFO head: {zero,h0} if compressed, else {h1,h0}; instr_err_o = OR of the err bits used.
REQ-023 SHALL, on instruction handshake, pop 1 halfword (compressed) or 2 (otherwise) and add 2 or 4 to pc_q; pc_o = pc_q.
REQ-024 SHALL support pop and fetch append in the same cycle; count_next = count - pop + push.
REQ-025 SHALL keep instr_o, pc_o, is_compressed_o and instr_err_o stable while instr_valid_o && !instr_ready_i.
REQ-026 SHALL, on flush_i, set count=0, pc_q=flush_pc_i with bit 0 cleared, and skip_q=flush_pc_i[1]; flush overrides any same-cycle handshake.
REQ-027 SHALL force instr_valid_o=0 in a cycle with flush_i=1.
REQ-028 SHALL have zero-cycle latency from FIFO contents to instr_o; a fetch word appended at edge N is visible after edge N.
REQ-029 SHALL wrap pc_q modulo 2^32 without error.
REQ-030 SHALL never overflow the FIFO; count > 3 is unreachable by construction.

Reset
REQ-031 SHALL, while rst_ni=0, set count=0, skip_q=BOOT_ADDR[1], pc_q=BOOT_ADDR with bit 0 cleared, and all halfword data and err bits to 0.
REQ-032 SHALL, while rst_ni=0, drive instr_valid_o=0, fetch_ready_o=0 (forced low during reset), instr_o=0, is_compressed_o=0 and instr_err_o=0.
REQ-033 SHALL, after reset release, drive fetch_ready_o=1 in the first cycle.
REQ-034 SHALL, on reset asserted mid-operation, discard all buffered halfwords and any partial instruction with no output handshake.

Verification
REQ-035 SHALL pass this scenario: fetch 32'h0013_0513 (addi), ready=1 -> instr_o=32'h0013_0513, is_compressed_o=0, pc_o=BOOT_ADDR, then pc_q advances by 4.
REQ-036 SHALL pass this scenario: fetch 32'h4505_0505 -> two instructions 32'h0000_0505 (pc 0) and 32'h0000_4505 (pc 2), both with is_compressed_o=1.
REQ-037 SHALL pass this scenario: fetch 32'h0513_0001, then 32'h4501_0013 -> c.nop at pc 0, 32'h0013_0513 at pc 2, c.li 32'h0000_4501 at pc 6.
REQ-038 SHALL pass this scenario: flush_pc_i=32'h0000_0102, fetch 32'h0505_FFFF -> one output, 32'h0000_0505 at pc 32'h0000_0102; low halfword dropped.
REQ-039 SHALL pass this scenario: halfword 16'h0513 with err=0 then 16'h0013 with err=1 -> instr_err_o=1 for 32'h0013_0513.
REQ-040 SHALL pass this scenario: instr_ready_i=0 for 5 cycles with count=3 -> fetch_ready_o=0 and outputs stable; release -> pop and refill in the same cycle.
